// File: rtl/sha_job_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// sha_job_ctrl_pkg
//   Shared definitions for the SHA-256 job sequencer: transaction opcodes,
//   bus module IDs, the sequencer state encoding and the Moore decode of
//   the transaction bus from the current state.
// ---------------------------------------------------------------------------
package sha_job_ctrl_pkg;

   // Transaction opcodes understood by the SHA accelerator.
   localparam logic [1:0] OP_LOAD_KEY     = 2'b00;
   localparam logic [1:0] OP_LOAD_TEXT    = 2'b01;
   localparam logic [1:0] OP_WRITE_RESULT = 2'b10;
   localparam logic [1:0] OP_HASH         = 2'b11;

   // Opcode 00 with source and destination both MEM is never a valid
   // accelerator command, so the SHA treats it as a bus no-op.
   localparam logic [1:0] OP_NOP          = OP_LOAD_KEY;

   // Module IDs on the transaction bus.
   localparam logic [1:0] MEM_ID = 2'b00;
   localparam logic [1:0] SHA_ID = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      HASH,
      RESULT,
      ACK,
      DONE
   } state_t;

   typedef struct packed {
      logic [1:0] opcode;
      logic [1:0] source_id;
      logic [1:0] dest_id;
   } xact_t;

   // Transaction bus fields for a given state. The SHA samples the opcode
   // in the very cycle the state changes, so this must stay a pure decode
   // of the state register and never depend on inputs.
   function automatic xact_t xact_decode(input state_t s);
      xact_t x;
      x = '{opcode: OP_NOP, source_id: MEM_ID, dest_id: MEM_ID};
      case (s)
         LOAD:    x = '{opcode: OP_LOAD_TEXT,    source_id: MEM_ID, dest_id: SHA_ID};
         HASH:    x = '{opcode: OP_HASH,         source_id: SHA_ID, dest_id: SHA_ID};
         RESULT:  x = '{opcode: OP_WRITE_RESULT, source_id: SHA_ID, dest_id: MEM_ID};
         default: ;
      endcase
      return x;
   endfunction

endpackage

// File: rtl/sha_job_watchdog.sv
// ---------------------------------------------------------------------------
// sha_job_watchdog
//   Saturating idle-cycle counter used to abort a stalled job phase.
//
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   clear    in   restart the count (state entry or byte handshake)
//   enable   in   count this cycle (phase is watched)
//   expired  out  count has reached TIMEOUT
// ---------------------------------------------------------------------------
module sha_job_watchdog #(
   parameter int TIMEOUT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int            W     = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

   logic [W-1:0] count;

   // NOTE: sequential state is always written with non-blocking assignments
   // so every flop samples the pre-edge values of its neighbours.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + W'(1);
      end
   end

   // Holds at LIMIT once reached; the sequencer leaves the phase on the
   // same edge, and the state change clears the count.
   assign expired = (count == LIMIT);

endmodule

// File: rtl/sha_job_ctrl.sv
// ---------------------------------------------------------------------------
// sha_job_ctrl
//   Job sequencer in front of the SHA-256 accelerator. A start request
//   latches a source and destination address, then the sequencer walks the
//   transaction bus through LOAD_TEXT, HASH, WRITE_RESULT and the ACK
//   handshake, gating the message bytes into the SHA and the digest bytes
//   out of it. Completion (or a watchdog abort) is reported with a one-cycle
//   done pulse, err marking the abort case.
//
//   clk, rst_n                    clock, asynchronous active-low reset
//   start, src_addr, dst_addr     job request and its addresses
//   busy, done, err               job status to the system controller
//   in_data/in_valid/in_ready     message byte stream from memory side
//   out_data/out_valid/out_ready  digest byte stream to memory side
//   sha_data_in/sha_valid_in/sha_ready_in     message bytes into the SHA
//   sha_data_out/sha_data_valid/sha_data_ready digest bytes from the SHA
//   sha_ack_valid/sha_module_id/sha_ack_ready completion ack from the SHA
//   opcode/source_id/dest_id/encdec/addr      transaction bus
// ---------------------------------------------------------------------------
module sha_job_ctrl
   import sha_job_ctrl_pkg::*;
#(
   parameter int MSG_BYTES = 32,
   parameter int DIG_BYTES = 32,
   parameter int HASH_HOLD = 4,
   parameter int TIMEOUT   = 1023
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [23:0] src_addr,
   input  logic [23:0] dst_addr,
   output logic        busy,
   output logic        done,
   output logic        err,
   input  logic [7:0]  in_data,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  sha_data_in,
   output logic        sha_valid_in,
   input  logic        sha_ready_in,
   input  logic [7:0]  sha_data_out,
   input  logic        sha_data_valid,
   output logic        sha_data_ready,
   input  logic        sha_ack_valid,
   input  logic [1:0]  sha_module_id,
   output logic        sha_ack_ready,
   output logic [1:0]  opcode,
   output logic [1:0]  source_id,
   output logic [1:0]  dest_id,
   output logic        encdec,
   output logic [23:0] addr
);

   localparam int                 HOLD_W    = $clog2(HASH_HOLD + 1);
   localparam logic [5:0]         MSG_LAST  = 6'(MSG_BYTES - 1);
   localparam logic [5:0]         DIG_LAST  = 6'(DIG_BYTES - 1);
   localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HASH_HOLD - 1);

   state_t              state;
   state_t              state_next;
   xact_t               xact;
   logic [5:0]          byte_cnt;
   logic [HOLD_W-1:0]   hold_cnt;
   logic [23:0]         src_q;
   logic [23:0]         dst_q;
   logic                aborted;
   logic                abort;
   logic                in_hs;
   logic                out_hs;
   logic                wd_clear;
   logic                wd_enable;
   logic                wd_expired;

   // Byte handshakes only count in the state that owns the stream.
   assign in_hs  = (state == LOAD)   && in_valid && sha_ready_in;
   assign out_hs = (state == RESULT) && sha_data_valid;

   // The watchdog restarts on every state entry and on every byte moved;
   // HASH is a fixed-length hold and is not watched.
   assign wd_clear  = (state_next != state) || in_hs || out_hs;
   assign wd_enable = (state == LOAD) || (state == RESULT) || (state == ACK);

   sha_job_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Next state and Moore / gated outputs
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default before the case so
      // no path through it can leave a value held, which would infer a latch.
      state_next     = state;
      abort          = 1'b0;
      sha_data_in    = '0;
      sha_valid_in   = 1'b0;
      in_ready       = 1'b0;
      out_data       = '0;
      out_valid      = 1'b0;
      sha_data_ready = 1'b0;
      sha_ack_ready  = 1'b0;
      addr           = '0;

      case (state)
         IDLE: begin
            if (start) state_next = LOAD;
         end
         LOAD: begin
            sha_data_in  = in_data;
            sha_valid_in = in_valid;
            in_ready     = sha_ready_in;
            addr         = src_q;
            // A byte arriving in the expiry cycle still counts as progress.
            if (in_hs) begin
               if (byte_cnt == MSG_LAST) state_next = HASH;
            end else if (wd_expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         HASH: begin
            if (hold_cnt == HOLD_LAST) state_next = RESULT;
         end
         RESULT: begin
            out_data       = sha_data_out;
            out_valid      = sha_data_valid;
            sha_data_ready = out_ready;
            addr           = dst_q;
            if (out_hs) begin
               if (byte_cnt == DIG_LAST) state_next = ACK;
            end else if (wd_expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         ACK: begin
            sha_ack_ready = 1'b1;
            // Acks from any other module are not ours and are ignored.
            if (sha_ack_valid && (sha_module_id == SHA_ID)) begin
               state_next = DONE;
            end else if (wd_expired) begin
               state_next = DONE;
               abort      = 1'b1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      xact = xact_decode(state);
   end

   assign opcode    = xact.opcode;
   assign source_id = xact.source_id;
   assign dest_id   = xact.dest_id;
   assign encdec    = 1'b0;

   // busy covers LOAD through DONE, so it drops the cycle after done.
   assign busy = (state != IDLE);
   assign done = (state == DONE);
   assign err  = (state == DONE) && aborted;

   // ------------------------------------------------------------------
   // Job datapath: addresses, byte and hold counters, abort flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         hold_cnt <= '0;
         src_q    <= '0;
         dst_q    <= '0;
         aborted  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_q    <= src_addr;
                  dst_q    <= dst_addr;
                  byte_cnt <= '0;
               end
            end
            LOAD: begin
               if (in_hs) byte_cnt <= byte_cnt + 6'd1;
               if (state_next == HASH) hold_cnt <= '0;
            end
            HASH: begin
               hold_cnt <= hold_cnt + HOLD_W'(1);
               if (hold_cnt == HOLD_LAST) byte_cnt <= '0;
            end
            RESULT: begin
               if (out_hs) byte_cnt <= byte_cnt + 6'd1;
            end
            default: ;
         endcase

         // Remember how DONE was reached so err can be a Moore output.
         if (state_next == DONE) aborted <= abort;
      end
   end

endmodule

// File: tb/tb_sha_job_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sha_job_ctrl
//   Directed bench for sha_job_ctrl. The bench plays the memory side and a
//   simple SHA core that returns the SHA-256 digest of bytes 00..1F.
//   Inputs change on the falling edge; outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_sha_job_ctrl;

   localparam int MSG = 32;
   localparam int DIG = 32;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [23:0] src_addr;
   logic [23:0] dst_addr;
   logic        busy;
   logic        done;
   logic        err;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  sha_data_in;
   logic        sha_valid_in;
   logic        sha_ready_in;
   logic [7:0]  sha_data_out;
   logic        sha_data_valid;
   logic        sha_data_ready;
   logic        sha_ack_valid;
   logic [1:0]  sha_module_id;
   logic        sha_ack_ready;
   logic [1:0]  opcode;
   logic [1:0]  source_id;
   logic [1:0]  dest_id;
   logic        encdec;
   logic [23:0] addr;

   int n_checks = 0;
   int n_fail   = 0;

   // SHA-256 of the 32 bytes 00 01 02 ... 1F.
   logic [255:0] digest = 256'h630dcd2966c4336691125448bbb25b4ff412a49c732db2c8abc1b8581bd710dd;
   logic [7:0]   golden [DIG];

   always #5 clk = ~clk;

   sha_job_ctrl #(
      .TIMEOUT (63)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .src_addr       (src_addr),
      .dst_addr       (dst_addr),
      .busy           (busy),
      .done           (done),
      .err            (err),
      .in_data        (in_data),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .sha_data_in    (sha_data_in),
      .sha_valid_in   (sha_valid_in),
      .sha_ready_in   (sha_ready_in),
      .sha_data_out   (sha_data_out),
      .sha_data_valid (sha_data_valid),
      .sha_data_ready (sha_data_ready),
      .sha_ack_valid  (sha_ack_valid),
      .sha_module_id  (sha_module_id),
      .sha_ack_ready  (sha_ack_ready),
      .opcode         (opcode),
      .source_id      (source_id),
      .dest_id        (dest_id),
      .encdec         (encdec),
      .addr           (addr)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      start          = 1'b0;
      in_data        = '0;
      in_valid       = 1'b0;
      out_ready      = 1'b0;
      sha_ready_in   = 1'b0;
      sha_data_out   = '0;
      sha_data_valid = 1'b0;
      sha_ack_valid  = 1'b0;
      sha_module_id  = 2'b00;
   endtask

   task automatic check_reset_outputs();
      check("rst_busy",    busy, 0);
      check("rst_done",    done, 0);
      check("rst_err",     err, 0);
      check("rst_in_rdy",  in_ready, 0);
      check("rst_out_vld", out_valid, 0);
      check("rst_sha_vld", sha_valid_in, 0);
      check("rst_sha_drdy", sha_data_ready, 0);
      check("rst_ack_rdy", sha_ack_ready, 0);
      check("rst_xact",    {opcode, source_id, dest_id}, 0);
      check("rst_addr",    addr, 0);
      check("rst_encdec",  encdec, 0);
   endtask

   task automatic start_job(input logic [23:0] s, input logic [23:0] d);
      @(negedge clk);
      clear_inputs();
      start    = 1'b1;
      src_addr = s;
      dst_addr = d;
      #1;
      check("idle_busy", busy, 0);
      check("idle_op", opcode, 2'b00);
   endtask

   // Memory side feeding bytes 00..1F. bp toggles in_valid every cycle and
   // stalls the SHA for 5 cycles; poke re-asserts start with new addresses.
   task automatic load_phase(input logic [23:0] s, input bit bp, input bit poke);
      int hs = 0;
      int c = 0;
      int stall_left = 0;
      bit stalled = 1'b0;
      while (hs < MSG) begin
         @(negedge clk);
         if (c >= 300) begin
            check("load_bound", hs, MSG);
            return;
         end
         if (bp && hs == 12 && !stalled) begin
            stalled    = 1'b1;
            stall_left = 5;
         end
         sha_ready_in = (stall_left == 0);
         if (stall_left > 0) stall_left--;
         in_valid = bp ? (c % 2 == 0) : 1'b1;
         in_data  = 8'(hs);
         if (poke && c == 3) begin
            start    = 1'b1;
            src_addr = 24'h123456;
            dst_addr = 24'h654321;
         end else begin
            start = 1'b0;
         end
         #1;
         check("load_op", opcode, 2'b01);
         check("load_ids", {source_id, dest_id}, 4'b0001);
         check("load_addr", addr, s);
         check("load_busy", busy, 1);
         check("load_in_rdy", in_ready, sha_ready_in);
         check("load_sha_vld", sha_valid_in, in_valid);
         if (in_valid && sha_ready_in) begin
            check("load_byte", sha_data_in, hs);
            hs++;
         end
         c++;
      end
   endtask

   // Stream inputs are held active to prove HASH gates them off.
   task automatic hash_phase();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         start          = 1'b0;
         in_valid       = 1'b1;
         sha_ready_in   = 1'b1;
         sha_data_valid = 1'b1;
         out_ready      = 1'b1;
         #1;
         check("hash_op", opcode, 2'b11);
         check("hash_ids", {source_id, dest_id}, 4'b0101);
         check("hash_addr", addr, 0);
         check("hash_gate", {in_ready, sha_valid_in, out_valid, sha_data_ready}, 0);
      end
   endtask

   task automatic result_phase(input logic [23:0] d, input int latency, input int nbytes);
      int k = 0;
      int c = 0;
      while (k < nbytes) begin
         @(negedge clk);
         in_valid       = 1'b0;
         sha_ready_in   = 1'b1;
         sha_data_valid = (c >= latency) && (c % 9 != 8);
         sha_data_out   = sha_data_valid ? golden[k] : 8'h00;
         out_ready      = (c % 3 != 2);
         #1;
         check("res_op", opcode, 2'b10);
         check("res_ids", {source_id, dest_id}, 4'b0100);
         check("res_addr", addr, d);
         check("res_drdy", sha_data_ready, out_ready);
         check("res_in_rdy", in_ready, 0);
         check("res_vld", out_valid, sha_data_valid);
         if (sha_data_valid) begin
            check("res_byte", out_data, golden[k]);
            k++;
         end
         c++;
      end
   endtask

   // Acks are presented one per cycle; only the last carries SHA_ID.
   task automatic ack_phase(input bit foreign);
      logic [1:0] ids [4];
      int n;
      ids[0] = 2'b10;
      ids[1] = 2'b11;
      ids[2] = 2'b00;
      ids[3] = 2'b01;
      n = foreign ? 4 : 1;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         sha_data_valid = 1'b0;
         sha_ready_in   = 1'b0;
         sha_ack_valid  = 1'b1;
         sha_module_id  = foreign ? ids[i] : 2'b01;
         #1;
         check("ack_op", opcode, 2'b00);
         check("ack_rdy", sha_ack_ready, 1);
         check("ack_done", done, 0);
         check("ack_out_vld", out_valid, 0);
      end
   endtask

   task automatic done_phase(input bit exp_err);
      @(negedge clk);
      clear_inputs();
      #1;
      check("done_pulse", done, 1);
      check("done_err", err, exp_err);
      check("done_busy", busy, 1);
      check("done_op", opcode, 2'b00);
      check("done_ack_rdy", sha_ack_ready, 0);
      @(negedge clk);
      #1;
      check("post_done", done, 0);
      check("post_err", err, 0);
      check("post_busy", busy, 0);
   endtask

   task automatic nominal_job(input logic [23:0] s, input logic [23:0] d);
      start_job(s, d);
      load_phase(s, 1'b0, 1'b0);
      hash_phase();
      result_phase(d, 5, DIG);
      ack_phase(1'b0);
      done_phase(1'b0);
   endtask

   initial begin
      for (int i = 0; i < DIG; i++) golden[i] = digest[255 - 8*i -: 8];
      clear_inputs();
      src_addr = '0;
      dst_addr = '0;
      rst_n    = 1'b0;

      // Reset state, with the stream inputs active to show the gating.
      repeat (2) @(negedge clk);
      in_valid = 1'b1; sha_ready_in = 1'b1; sha_data_valid = 1'b1; out_ready = 1'b1;
      #1;
      check_reset_outputs();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;

      // Nominal job.
      nominal_job(24'h000100, 24'h000200);

      // LOAD backpressure with a mid-job start that must be ignored.
      start_job(24'h00ABCD, 24'h00DCBA);
      load_phase(24'h00ABCD, 1'b1, 1'b1);
      hash_phase();
      result_phase(24'h00DCBA, 3, DIG);
      ack_phase(1'b0);
      done_phase(1'b0);

      // Watchdog: no digest bytes, abort 64 cycles after RESULT entry.
      start_job(24'h000300, 24'h000400);
      load_phase(24'h000300, 1'b0, 1'b0);
      hash_phase();
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         sha_data_valid = 1'b0;
         #1;
         check("wd_op", opcode, 2'b10);
         check("wd_done", done, 0);
      end
      done_phase(1'b1);

      // Foreign acks are ignored; the SHA ack then completes the job.
      start_job(24'h000500, 24'h000600);
      load_phase(24'h000500, 1'b0, 1'b0);
      hash_phase();
      result_phase(24'h000600, 0, DIG);
      ack_phase(1'b1);
      done_phase(1'b0);

      // Reset after 10 digest bytes, then a clean job.
      start_job(24'h000700, 24'h000800);
      load_phase(24'h000700, 1'b0, 1'b0);
      hash_phase();
      result_phase(24'h000800, 2, 10);
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b1; sha_ready_in = 1'b1; sha_data_valid = 1'b1;
      out_ready = 1'b1; sha_ack_valid = 1'b1; sha_module_id = 2'b01;
      #1;
      check_reset_outputs();
      @(negedge clk);
      clear_inputs();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check("rst_no_done", done, 0);
         check("rst_idle", busy, 0);
      end
      nominal_job(24'h000100, 24'h000200);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1, "bench time limit reached");
   end

endmodule
